// File: rtl/bcd_converter_if.sv
//------------------------------------------------------------------------------
// bcd_converter_if : start/done handshake and result bus of the binary-to-BCD
//                    converter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bcd_converter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  clr;
  logic                  start;
  logic [WIDTH-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic                  valid;
  logic                  neg;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output clr, start, binary,
    input  busy, done, valid, neg, bcd
  );

  modport slave (
    input  clr, start, binary,
    output busy, done, valid, neg, bcd
  );
endinterface

`default_nettype wire

// File: rtl/bcd_converter.sv
//------------------------------------------------------------------------------
// bcd_converter : signed binary to sign + packed BCD, one double-dabble
//                 iteration per clock, start/done handshake.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  wire logic      clk,
  input  wire logic      rst,
  bcd_converter_if.slave bus
);

  localparam int         c_BCD_W     = 4 * DIGITS;
  localparam logic [4:0] c_LAST_ITER = 5'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [4:0]           r_count;
  logic [WIDTH-1:0]     r_mag;
  logic [c_BCD_W-1:0]   r_work;
  logic                 r_sign;
  logic [c_BCD_W-1:0]   r_bcd;
  logic                 r_neg;
  logic                 r_valid;
  logic                 r_done;
  logic [c_BCD_W-1:0]   w_work_adj;
  logic [WIDTH-1:0]     w_mag;
  logic                 w_accept;

  // A start seen while done is still high is dropped; clr always wins.
  assign w_accept = bus.start && (r_state == S_IDLE) && !r_done && !bus.clr;
  assign w_mag    = bus.binary[WIDTH-1] ? (~bus.binary + WIDTH'(1)) : bus.binary;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_work_adj[4*g +: 4] = (r_work[4*g +: 4] >= 4'd5) ?
                                  (r_work[4*g +: 4] + 4'd3) : r_work[4*g +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_SHIFT;
      S_SHIFT: if (r_count == c_LAST_ITER) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (bus.clr) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_mag   <= '0;
      r_work  <= '0;
      r_sign  <= 1'b0;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else if (bus.clr) begin
      r_count <= '0;
      r_mag   <= '0;
      r_work  <= '0;
      r_sign  <= 1'b0;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sign  <= bus.binary[WIDTH-1];
            r_mag   <= w_mag;
            r_work  <= '0;
            r_count <= '0;
          end
        end
        S_SHIFT: begin
          {r_work, r_mag} <= {w_work_adj, r_mag} << 1;
          r_count         <= r_count + 5'd1;
        end
        S_DONE: begin
          r_bcd   <= r_work;
          r_neg   <= r_sign && (|r_work);
          r_valid <= 1'b1;
          r_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = r_done;
  assign bus.valid = r_valid;
  assign bus.neg   = r_neg;
  assign bus.bcd   = r_bcd;

endmodule

`default_nettype wire

// File: tb/tb_bcd_converter.sv
//------------------------------------------------------------------------------
// tb_bcd_converter : directed and random checks of bcd_converter against a
//                    decimal-arithmetic reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  bcd_converter_if #(.WIDTH(16), .DIGITS(5)) bus ();

  bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input logic [15:0] v);
    int          m;
    logic [19:0] r;
    m = $signed(v);
    if (m < 0) m = -m;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_neg(input logic [15:0] v);
    return $signed(v) < 0;
  endfunction

  task automatic start_op(input logic [15:0] v);
    @(negedge clk);
    bus.binary = v;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  task automatic convert(input logic [15:0] v, input string tag);
    logic [19:0] pb, eb;
    logic        pn, pv, en;
    pb = bus.bcd;
    pn = bus.neg;
    pv = bus.valid;
    eb = ref_bcd(v);
    en = ref_neg(v);
    start_op(v);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold"}, 32'({bus.done, bus.busy, bus.valid, bus.neg, bus.bcd}),
            32'({1'b0, 1'b1, pv, pn, pb}));
    end
    @(posedge clk);
    #1;
    check({tag, "_done"},  32'(bus.done),  32'd1);
    check({tag, "_idle"},  32'(bus.busy),  32'd0);
    check({tag, "_bcd"},   32'(bus.bcd),   32'(eb));
    check({tag, "_neg"},   32'(bus.neg),   32'(en));
    check({tag, "_valid"}, 32'(bus.valid), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(bus.done),  32'd0);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    bus.clr    = 1'b0;
    bus.start  = 1'b0;
    bus.binary = '0;
    rst        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({bus.busy, bus.done, bus.valid, bus.neg, bus.bcd}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    convert(16'h3039, "c12345");
    check("c12345_lit", 32'(bus.bcd), 32'h12345);
    convert(16'hFF82, "m126");
    check("m126_lit", 32'({bus.neg, bus.bcd}), 32'h100126);
    convert(16'h0000, "zero");
    convert(16'h8000, "min");
    check("min_lit", 32'({bus.neg, bus.bcd}), 32'h132768);
    convert(16'h7FFF, "max");
    convert(16'hFFFF, "m1");
    convert(16'h4000, "p16384");
    check("p16384_lit", 32'(bus.bcd), 32'h16384);

    // start during SHIFT and during the done cycle must both be dropped
    start_op(16'h3039);
    repeat (4) @(posedge clk);
    start_op(16'h0001);
    repeat (12) @(posedge clk);
    #1;
    check("ign_done", 32'(bus.done), 32'd1);
    check("ign_bcd",  32'(bus.bcd),  32'h12345);
    start_op(16'h0001);
    check("ign_donecyc", 32'({bus.busy, bus.done}), 32'd0);
    convert(16'h0001, "restart");

    start_op(16'h0100);
    repeat (7) @(posedge clk);
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    check("clr_outs", 32'({bus.busy, bus.done, bus.valid, bus.neg, bus.bcd}), 32'd0);
    watch_no_done("clr_no_done", 20);

    @(negedge clk);
    bus.clr    = 1'b1;
    bus.start  = 1'b1;
    bus.binary = 16'h1234;
    @(posedge clk);
    #1;
    bus.clr   = 1'b0;
    bus.start = 1'b0;
    check("clr_start_busy", 32'(bus.busy), 32'd0);
    watch_no_done("clr_start_no_done", 20);

    for (int i = 0; i < 24; i++) begin
      v = 16'($urandom);
      convert(v, "rand");
    end

    start_op(16'h7FFF);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_outs", 32'({bus.busy, bus.done, bus.valid, bus.neg, bus.bcd}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("arst_idle", 32'({bus.busy, bus.done, bus.valid}), 32'd0);
    convert(16'h0064, "p100");
    check("p100_lit", 32'(bus.bcd), 32'h00100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
